// File: rtl/ram_dma_pkg.sv
// ---------------------------------------------------------------------------
// ram_dma_pkg
// Shared definitions for the RAM copy/fill engine:
//   - state_t   : sequencer states (IDLE, RD, WAIT, WR, DONE)
//   - MODE_COPY / MODE_FILL : encodings of the mode command input
//   - AW_DEF / DW_DEF       : default RAM address / data widths (256 x 16)
// ---------------------------------------------------------------------------
package ram_dma_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/ram_copy_ptr.sv
// ---------------------------------------------------------------------------
// ram_copy_ptr
// Loadable AW-bit address pointer with increment enable. Wraps naturally
// from all-ones back to zero. Load has priority over increment.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (pointer -> 0)
//   i_load     in   load i_load_val on this edge
//   i_load_val in   base address to load
//   i_inc      in   advance pointer by one on this edge
//   o_ptr      out  current pointer value
// ---------------------------------------------------------------------------
module ram_copy_ptr
  import ram_dma_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_inc,
  output logic [AW-1:0] o_ptr
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PTR_ONE;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_copy_engine.sv
// ---------------------------------------------------------------------------
// ram_copy_engine
// Simple DMA sequencer for a 256x16 single-port RAM. On an accepted start it
// either copies len words from src_addr to dst_addr (ascending, read before
// write for every word) or fills len words at dst_addr with fill_val. A
// running modulo-2^DW sum of all written words is exposed on sum.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               command strobe, only honoured in IDLE
//   mode                0 = copy, 1 = fill
//   src_addr, dst_addr  base addresses
//   len                 word count 0..2^AW
//   fill_val            fill pattern
//   busy                high in every state but IDLE
//   done                one-cycle completion pulse (DONE state)
//   sum                 checksum of words written by last/current command
//   mem_addr, mem_we, mem_d   RAM write/read port drive
//   mem_o               RAM read data
// ---------------------------------------------------------------------------
module ram_copy_engine
  import ram_dma_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_o
);

  localparam logic [AW:0] REM_ONE = {{AW{1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_next;
  logic          r_mode;
  logic [AW:0]   r_rem;
  logic [DW-1:0] r_word;
  logic [DW-1:0] r_sum;
  logic [AW-1:0] w_src_ptr;
  logic [AW-1:0] w_dst_ptr;
  logic          w_accept;
  logic          w_capture;
  logic          w_wr;

  assign w_accept = (r_state == IDLE) && start;
  assign w_wr     = (r_state == WR);

  // Read data is sampled in the last cycle the source address is held:
  // RD itself for a combinational RAM, WAIT for a registered-output RAM.
  assign w_capture = (RD_LAT == 0) ? (r_state == RD) : (r_state == WAIT);

  ram_copy_ptr #(.AW(AW)) u_src_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (src_addr),
    .i_inc      (w_wr),
    .o_ptr      (w_src_ptr)
  );

  ram_copy_ptr #(.AW(AW)) u_dst_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_val (dst_addr),
    .i_inc      (w_wr),
    .o_ptr      (w_dst_ptr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_state_next = DONE;
          end else if (mode == MODE_FILL) begin
            w_state_next = WR;
          end else begin
            w_state_next = RD;
          end
        end
      end
      RD:   w_state_next = (RD_LAT == 0) ? WR : WAIT;
      WAIT: w_state_next = WR;
      WR: begin
        if (r_rem == REM_ONE) begin
          w_state_next = DONE;
        end else if (r_mode == MODE_FILL) begin
          w_state_next = WR;
        end else begin
          w_state_next = RD;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath. r_word doubles as the latched fill pattern: in fill mode it is
  // loaded once at accept and never overwritten, so WR always writes r_word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_COPY;
      r_rem  <= '0;
      r_word <= '0;
      r_sum  <= '0;
    end else if (w_accept) begin
      r_mode <= mode;
      r_rem  <= len;
      r_word <= fill_val;
      r_sum  <= '0;
    end else begin
      if (w_capture) begin
        r_word <= mem_o;
      end
      if (w_wr) begin
        r_rem <= r_rem - REM_ONE;
        r_sum <= r_sum + r_word;
      end
    end
  end

  // Output decode: registered state and pointers only, nothing from start.
  always_comb begin
    busy     = (r_state != IDLE);
    done     = (r_state == DONE);
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_d    = '0;
    case (r_state)
      RD, WAIT: mem_addr = w_src_ptr;
      WR: begin
        mem_addr = w_dst_ptr;
        mem_we   = 1'b1;
        mem_d    = r_word;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign sum = r_sum;

endmodule
